// File: rtl/window_gen_5x5_if.sv
// Stream bundle for the 5x5 window generator: pixel input side and window output side.
// Optional WINDOW_GEN_POS_OUT_EN adds the m_row/m_col window-centre signals.
interface window_gen_5x5_if #(
    parameter int pixel_width = 9
`ifdef WINDOW_GEN_POS_OUT_EN
    ,
    parameter int row_w = 9,
    parameter int col_w = 9
`endif
);
    logic s_valid;
    logic s_ready;
    logic signed [pixel_width-1:0] s_pixel;
    logic m_valid;
    logic m_ready;
    logic frame_done;
    logic signed [pixel_width-1:0] pixel1, pixel2, pixel3, pixel4, pixel5;
    logic signed [pixel_width-1:0] pixel6, pixel7, pixel8, pixel9, pixel10;
    logic signed [pixel_width-1:0] pixel11, pixel12, pixel13, pixel14, pixel15;
    logic signed [pixel_width-1:0] pixel16, pixel17, pixel18, pixel19, pixel20;
    logic signed [pixel_width-1:0] pixel21, pixel22, pixel23, pixel24, pixel25;
`ifdef WINDOW_GEN_POS_OUT_EN
    logic [row_w-1:0] m_row;
    logic [col_w-1:0] m_col;
`endif

    modport master (
        output s_valid, s_pixel, m_ready,
        input s_ready, m_valid, frame_done,
        input pixel1, pixel2, pixel3, pixel4, pixel5,
        input pixel6, pixel7, pixel8, pixel9, pixel10,
        input pixel11, pixel12, pixel13, pixel14, pixel15,
        input pixel16, pixel17, pixel18, pixel19, pixel20,
        input pixel21, pixel22, pixel23, pixel24, pixel25
`ifdef WINDOW_GEN_POS_OUT_EN
        , input m_row, m_col
`endif
    );

    modport slave (
        input s_valid, s_pixel, m_ready,
        output s_ready, m_valid, frame_done,
        output pixel1, pixel2, pixel3, pixel4, pixel5,
        output pixel6, pixel7, pixel8, pixel9, pixel10,
        output pixel11, pixel12, pixel13, pixel14, pixel15,
        output pixel16, pixel17, pixel18, pixel19, pixel20,
        output pixel21, pixel22, pixel23, pixel24, pixel25
`ifdef WINDOW_GEN_POS_OUT_EN
        , output m_row, m_col
`endif
    );
endinterface

// File: rtl/window_gen_5x5.sv
// Streaming 5x5 sliding-window generator with four line buffers and valid/ready flow.
// Optional WINDOW_GEN_POS_OUT_EN registers the window centre on bus.m_row/bus.m_col.
module window_gen_5x5 #(
    parameter int pixel_width = 9,
    parameter int img_width = 512,
    parameter int img_height = 512
) (
    input logic clk,
    input logic rst_n,
    window_gen_5x5_if.slave bus
);
    localparam int CW = $clog2(img_width);
    localparam int RW = $clog2(img_height);
    localparam logic [CW-1:0] COL_LAST = CW'(img_width - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(img_height - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_END} state_t;
    typedef logic signed [pixel_width-1:0] pix_t;

    state_t state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    pix_t lb [4][img_width];
    pix_t win [5][5];
    pix_t column [5];
    logic accept;
    logic line_end;
    logic frame_end;
    logic win_done;

    assign bus.s_ready = (state != S_END) && (!bus.m_valid || bus.m_ready);
    assign accept = bus.s_valid && bus.s_ready;
    assign line_end = col == COL_LAST;
    assign frame_end = line_end && (row == ROW_LAST);
    assign win_done = (row >= RW'(4)) && (col >= CW'(4));

    // 5-tall column at the current x: oldest buffered row on top, new pixel at bottom
    always_comb begin
        column[0] = lb[3][col];
        column[1] = lb[2][col];
        column[2] = lb[1][col];
        column[3] = lb[0][col];
        column[4] = bus.s_pixel;
    end

    // line buffers shift down one row at the accepted column; never cleared
    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0][col] <= bus.s_pixel;
            for (int k = 1; k < 4; k++) begin
                lb[k][col] <= lb[k-1][col];
            end
        end
    end

    // position counters, window shift register, output handshake and frame FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            col <= '0;
            row <= '0;
            bus.m_valid <= 1'b0;
            bus.frame_done <= 1'b0;
            for (int k = 0; k < 5; k++) begin
                for (int j = 0; j < 5; j++) begin
                    win[k][j] <= '0;
                end
            end
        end else begin
            bus.frame_done <= 1'b0;
            if (bus.m_valid && bus.m_ready) begin
                bus.m_valid <= 1'b0;
            end
            if (accept) begin
                for (int k = 0; k < 5; k++) begin
                    for (int j = 0; j < 4; j++) begin
                        win[k][j] <= win[k][j+1];
                    end
                    win[k][4] <= column[k];
                end
                if (win_done) begin
                    bus.m_valid <= 1'b1;
                end
                col <= line_end ? '0 : col + 1'b1;
                if (line_end) begin
                    row <= frame_end ? '0 : row + 1'b1;
                end
            end
            unique case (state)
                S_IDLE: begin
                    if (accept) state <= S_FILL;
                end
                S_FILL: begin
                    if (accept && line_end && row == RW'(3)) state <= S_RUN;
                end
                S_RUN: begin
                    if (accept && frame_end) begin
                        state <= S_END;
                        bus.frame_done <= 1'b1;
                    end
                end
                S_END: begin
                    if (!bus.m_valid || bus.m_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef WINDOW_GEN_POS_OUT_EN
    // window centre, registered alongside the window it describes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.m_row <= '0;
            bus.m_col <= '0;
        end else if (accept && win_done) begin
            bus.m_row <= row - RW'(2);
            bus.m_col <= col - CW'(2);
        end
    end
`endif

    assign bus.pixel1 = win[0][0];
    assign bus.pixel2 = win[0][1];
    assign bus.pixel3 = win[0][2];
    assign bus.pixel4 = win[0][3];
    assign bus.pixel5 = win[0][4];
    assign bus.pixel6 = win[1][0];
    assign bus.pixel7 = win[1][1];
    assign bus.pixel8 = win[1][2];
    assign bus.pixel9 = win[1][3];
    assign bus.pixel10 = win[1][4];
    assign bus.pixel11 = win[2][0];
    assign bus.pixel12 = win[2][1];
    assign bus.pixel13 = win[2][2];
    assign bus.pixel14 = win[2][3];
    assign bus.pixel15 = win[2][4];
    assign bus.pixel16 = win[3][0];
    assign bus.pixel17 = win[3][1];
    assign bus.pixel18 = win[3][2];
    assign bus.pixel19 = win[3][3];
    assign bus.pixel20 = win[3][4];
    assign bus.pixel21 = win[4][0];
    assign bus.pixel22 = win[4][1];
    assign bus.pixel23 = win[4][2];
    assign bus.pixel24 = win[4][3];
    assign bus.pixel25 = win[4][4];
endmodule

// File: tb/tb_window_gen_5x5.sv
// Self-checking bench for window_gen_5x5 on an 8x6 frame.
// Scoreboard: expected windows queued on input accept, compared on output consume.
module tb_window_gen_5x5;
    localparam int W = 8;
    localparam int H = 6;
    localparam int PW = 9;

    typedef logic [25*PW-1:0] win_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

`ifdef WINDOW_GEN_POS_OUT_EN
    window_gen_5x5_if #(.pixel_width(PW), .row_w(3), .col_w(3)) bus ();
`else
    window_gen_5x5_if #(.pixel_width(PW)) bus ();
`endif

    window_gen_5x5 #(
        .pixel_width(PW),
        .img_width(W),
        .img_height(H)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    logic signed [PW-1:0] img [H][W];
    win_t q[$];
    win_t dut_win, first_win, second_win, last_win, exp_w;
    int checks = 0;
    int errors = 0;
    int mr = 0, mc = 0, acc_cnt = 0, win_cnt = 0;
    int fd_cnt = 0, srl_cnt = 0, cyc = 0, acc44 = -1, first_mv = -1;

    assign dut_win = {bus.pixel25, bus.pixel24, bus.pixel23, bus.pixel22, bus.pixel21,
                      bus.pixel20, bus.pixel19, bus.pixel18, bus.pixel17, bus.pixel16,
                      bus.pixel15, bus.pixel14, bus.pixel13, bus.pixel12, bus.pixel11,
                      bus.pixel10, bus.pixel9, bus.pixel8, bus.pixel7, bus.pixel6,
                      bus.pixel5, bus.pixel4, bus.pixel3, bus.pixel2, bus.pixel1};

    function automatic win_t exp_win(input int r, input int c);
        win_t w;
        w = '0;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 5; j++) begin
                w[(5*k+j)*PW +: PW] = img[r-4+k][c-4+j];
            end
        end
        return w;
    endfunction

    // scoreboard: pop/compare on consume, then push on accept
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (bus.frame_done) fd_cnt++;
            if (!bus.s_ready) srl_cnt++;
            if (bus.m_valid && first_mv < 0) first_mv = cyc;
            if (bus.m_valid && bus.m_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL window_extra: got %h required none", dut_win);
                end else begin
                    exp_w = q.pop_front();
                    if (dut_win !== exp_w) begin
                        errors++;
                        $display("FAIL window_%0d: got %h required %h", win_cnt, dut_win, exp_w);
                    end
                end
                if (win_cnt == 0) first_win = dut_win;
                if (win_cnt == 1) second_win = dut_win;
                last_win = dut_win;
                win_cnt++;
            end
            if (bus.s_valid && bus.s_ready) begin
                if (mr == 4 && mc == 4) acc44 = cyc;
                if (mr >= 4 && mc >= 4) q.push_back(exp_win(mr, mc));
                acc_cnt++;
                if (mc == W - 1) begin
                    mc = 0;
                    mr = (mr == H - 1) ? 0 : mr + 1;
                end else begin
                    mc++;
                end
            end
        end
    end

    task automatic clr();
        q.delete();
        mr = 0; mc = 0; acc_cnt = 0; win_cnt = 0;
        fd_cnt = 0; srl_cnt = 0; cyc = 0; acc44 = -1; first_mv = -1;
    endtask

    task automatic fill_img(input bit neg);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                img[r][c] = PW'(16 * r + c);
            end
        end
        if (neg) img[4][4] = 9'sh100;
    endtask

    task automatic push_pixel(input logic signed [PW-1:0] p, input int gap);
        bit acc;
        acc = 1'b0;
        for (int g = 0; g < gap; g++) begin
            bus.s_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b1;
        bus.s_pixel = p;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = bus.s_ready;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got s_ready 0 required 1");
        end
    endtask

    task automatic send_frame(input int gap);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                push_pixel(img[r][c], gap);
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || bus.m_valid) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        bus.s_valid = 1'b0;
        bus.s_pixel = '0;
        bus.m_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1) begin
            errors++; $display("FAIL reset_s_ready: got %b required 1", bus.s_ready);
        end
        checks++;
        if (bus.m_valid !== 1'b0) begin
            errors++; $display("FAIL reset_m_valid: got %b required 0", bus.m_valid);
        end
        checks++;
        if (bus.frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_frame_done: got %b required 0", bus.frame_done);
        end
        checks++;
        if (dut_win !== '0) begin
            errors++; $display("FAIL reset_window: got %h required 0", dut_win);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        fill_img(1'b0);
        clr();
        bus.m_ready = 1'b1;
        send_frame(0);
        drain();
        checks++;
        if (win_cnt != 8) begin
            errors++; $display("FAIL basic_count: got %0d required 8", win_cnt);
        end
        checks++;
        if (first_mv - acc44 != 1) begin
            errors++; $display("FAIL basic_latency: got %0d required 1", first_mv - acc44);
        end
        checks++;
        if (first_win[0 +: PW] !== 9'd0) begin
            errors++; $display("FAIL basic_pixel1: got %0d required 0", first_win[0 +: PW]);
        end
        checks++;
        if (first_win[12*PW +: PW] !== 9'd34) begin
            errors++; $display("FAIL basic_pixel13: got %0d required 34", first_win[12*PW +: PW]);
        end
        checks++;
        if (first_win[24*PW +: PW] !== 9'd68) begin
            errors++; $display("FAIL basic_pixel25: got %0d required 68", first_win[24*PW +: PW]);
        end
        checks++;
        if (last_win[24*PW +: PW] !== 9'd87) begin
            errors++; $display("FAIL basic_last: got %0d required 87", last_win[24*PW +: PW]);
        end
        checks++;
        if (fd_cnt != 1) begin
            errors++; $display("FAIL basic_frame_done: got %0d required 1", fd_cnt);
        end
    endtask

    task automatic test_backpressure();
        fill_img(1'b0);
        clr();
        bus.m_ready = 1'b1;
        fork
            send_frame(0);
            begin
                int t;
                int a0;
                win_t ew;
                t = 0;
                ew = exp_win(4, 5);
                while (!(bus.m_valid && dut_win === ew) && t < 200) begin
                    @(posedge clk); #1;
                    t++;
                end
                if (t >= 200) begin
                    checks++; errors++;
                    $display("FAIL bp_timeout: got no window (4,5) required one");
                end
                bus.m_ready = 1'b0;
                a0 = acc_cnt;
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if (dut_win !== ew || bus.m_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL bp_hold: got %h/%b required %h/1", dut_win, bus.m_valid, ew);
                    end
                    checks++;
                    if (bus.s_ready !== 1'b0) begin
                        errors++; $display("FAIL bp_s_ready: got %b required 0", bus.s_ready);
                    end
                end
                @(posedge clk); #1;
                checks++;
                if (acc_cnt != a0) begin
                    errors++; $display("FAIL bp_accepts: got %0d required %0d", acc_cnt, a0);
                end
                bus.m_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (win_cnt != 8) begin
            errors++; $display("FAIL bp_count: got %0d required 8", win_cnt);
        end
    endtask

    task automatic test_sign();
        fill_img(1'b1);
        clr();
        bus.m_ready = 1'b1;
        send_frame(0);
        drain();
        checks++;
        if (first_win[24*PW +: PW] !== 9'h100) begin
            errors++; $display("FAIL sign_pixel25: got %h required 100", first_win[24*PW +: PW]);
        end
        checks++;
        if (second_win[23*PW +: PW] !== 9'h100) begin
            errors++; $display("FAIL sign_pixel24: got %h required 100", second_win[23*PW +: PW]);
        end
        checks++;
        if (win_cnt != 8) begin
            errors++; $display("FAIL sign_count: got %0d required 8", win_cnt);
        end
    endtask

    task automatic test_back_to_back();
        fill_img(1'b0);
        clr();
        bus.m_ready = 1'b1;
        send_frame(0);
        send_frame(0);
        drain();
        checks++;
        if (fd_cnt != 2) begin
            errors++; $display("FAIL b2b_frame_done: got %0d required 2", fd_cnt);
        end
        checks++;
        if (srl_cnt != 2) begin
            errors++; $display("FAIL b2b_s_ready_low: got %0d required 2", srl_cnt);
        end
        checks++;
        if (win_cnt != 16) begin
            errors++; $display("FAIL b2b_count: got %0d required 16", win_cnt);
        end
    endtask

    task automatic test_mid_reset();
        fill_img(1'b0);
        clr();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push_pixel(img[i / W][i % W], 0);
        end
        checks++;
        if (acc_cnt != 20) begin
            errors++; $display("FAIL mrst_accepts: got %0d required 20", acc_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || dut_win !== '0) begin
            errors++; $display("FAIL mrst_async: got %b/%h required 0/0", bus.m_valid, dut_win);
        end
        checks++;
        if (bus.s_ready !== 1'b1) begin
            errors++; $display("FAIL mrst_s_ready: got %b required 1", bus.s_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        clr();
        send_frame(0);
        drain();
        checks++;
        if (win_cnt != 8) begin
            errors++; $display("FAIL mrst_count: got %0d required 8", win_cnt);
        end
        checks++;
        if (first_win[12*PW +: PW] !== 9'd34) begin
            errors++; $display("FAIL mrst_pixel13: got %0d required 34", first_win[12*PW +: PW]);
        end
        checks++;
        if (last_win[24*PW +: PW] !== 9'd87) begin
            errors++; $display("FAIL mrst_last: got %0d required 87", last_win[24*PW +: PW]);
        end
    endtask

    task automatic test_gaps();
        fill_img(1'b0);
        clr();
        bus.m_ready = 1'b1;
        send_frame(1);
        drain();
        checks++;
        if (win_cnt != 8) begin
            errors++; $display("FAIL gaps_count: got %0d required 8", win_cnt);
        end
        checks++;
        if (last_win[24*PW +: PW] !== 9'd87) begin
            errors++; $display("FAIL gaps_last: got %0d required 87", last_win[24*PW +: PW]);
        end
        checks++;
        if (fd_cnt != 1) begin
            errors++; $display("FAIL gaps_frame_done: got %0d required 1", fd_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_sign();
        test_back_to_back();
        test_mid_reset();
        test_gaps();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
